// File: rtl/led_chaser_pwm_pkg.sv
// led_pkg: shared mode encodings and direction constants for the LED chaser
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_chaser_pwm_channel.sv
// pwm_channel: one LED output, compares the shared PWM counter against its brightness
module pwm_channel #(
    parameter int PWM_W      = 10,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] pwm_ctr_i,
    input  logic [PWM_W-1:0] bright_i,
    output logic             led_o
);

    logic led_q;

    // Pin register: on while the counter is below brightness, polarity applied here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= ACTIVE_LOW;
        else        led_q <= (pwm_ctr_i < bright_i) ^ ACTIVE_LOW;
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_chaser_pwm.sv
// led_chaser_pwm: N-channel LED scanner with neighbour cross-fade and per-channel PWM
module led_chaser_pwm
    import led_pkg::*;
#(
    parameter int N_LEDS     = 4,
    parameter int PWM_W      = 10,
    parameter int FRAC_W     = 21,
    parameter int SPEED_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [1:0]                mode_i,
    input  logic [SPEED_W-1:0]        speed_i,
    output logic [N_LEDS-1:0]         led_o,
    output logic [$clog2(N_LEDS)-1:0] pos_o,
    output logic                      dir_o
);

    localparam int               IDX_W    = $clog2(N_LEDS);
    localparam int               POS_W    = IDX_W + FRAC_W;
    localparam logic [POS_W:0]   ONE      = (POS_W+1)'(1);
    localparam logic [POS_W:0]   SPAN     = (POS_W+1)'(N_LEDS) << FRAC_W;
    localparam logic [POS_W:0]   TOP_FULL = SPAN - ONE;
    localparam logic [POS_W:0]   TOP_BR   = (ONE << FRAC_W) - ONE;
    localparam logic [PWM_W-1:0] BMAX     = '1;

    logic [POS_W-1:0] acc_q, acc_d;
    logic             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic [POS_W:0]   spd_w, sum_w, top_w;
    logic [IDX_W-1:0] idx_w;
    logic [PWM_W-1:0] frac_w;
    logic [PWM_W-1:0] pwm_ctr_q;
    logic [PWM_W-1:0] bright_d [N_LEDS];
    logic [PWM_W-1:0] bright_q [N_LEDS];
    int               fin, fout;

    // Extra headroom bit keeps acc+speed from wrapping silently before the range checks
    assign mode_d = mode_e'(mode_i);
    assign spd_w  = (POS_W+1)'(speed_i);
    assign sum_w  = {1'b0, acc_q} + spd_w;
    assign top_w  = (mode_q == MODE_BREATHE) ? TOP_BR : TOP_FULL;
    assign idx_w  = acc_q[POS_W-1:FRAC_W];
    assign frac_w = acc_q[FRAC_W-1 -: PWM_W];

    // State register: position accumulator, sweep direction, registered mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_BOUNCE;
        end else begin
            acc_q  <= acc_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
        end
    end

    // Next state: a mode change restarts from slot 0 ahead of enable, then per-mode stepping
    always_comb begin
        acc_d = acc_q;
        dir_d = dir_q;
        if (mode_d != mode_q) begin
            acc_d = '0;
            dir_d = DIR_UP;
        end else if (enable_i && mode_q == MODE_WRAP) begin
            acc_d = (sum_w >= SPAN) ? POS_W'(sum_w - SPAN) : POS_W'(sum_w);
            dir_d = DIR_UP;
        end else if (enable_i && mode_q != MODE_HOLD) begin
            if (dir_q == DIR_UP) begin
                acc_d = (sum_w > top_w) ? POS_W'(top_w) : POS_W'(sum_w);
                dir_d = (sum_w > top_w) ? DIR_DOWN : DIR_UP;
            end else begin
                acc_d = ({1'b0, acc_q} < spd_w) ? '0 : acc_q - spd_w[POS_W-1:0];
                dir_d = ({1'b0, acc_q} < spd_w) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    // Outputs straight from the state registers
    always_comb begin
        pos_o = idx_w;
        dir_o = dir_q;
    end

    // Brightness: active slot full, upper neighbour fades in, lower neighbour fades out
    always_comb begin
        fin  = 0;
        fout = 0;
        for (int i = 0; i < N_LEDS; i++) begin
            fin  = (mode_q == MODE_WRAP) ? (i + N_LEDS - 1) % N_LEDS : i - 1;
            fout = (mode_q == MODE_WRAP) ? (i + 1) % N_LEDS : i + 1;
            bright_d[i] = (mode_q == MODE_BREATHE) ? frac_w :
                          (int'(idx_w) == i)       ? BMAX :
                          (int'(idx_w) == fin)     ? frac_w :
                          (int'(idx_w) == fout)    ? BMAX - frac_w : '0;
        end
    end

    // Brightness pipeline stage and free-running PWM counter shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_ctr_q <= '0;
            for (int i = 0; i < N_LEDS; i++) bright_q[i] <= '0;
        end else begin
            pwm_ctr_q <= pwm_ctr_q + PWM_W'(1);
            bright_q  <= bright_d;
        end
    end

    for (genvar c = 0; c < N_LEDS; c++) begin : g_ch
        pwm_channel #(
            .PWM_W     (PWM_W),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .pwm_ctr_i(pwm_ctr_q),
            .bright_i (bright_q[c]),
            .led_o    (led_o[c])
        );
    end

endmodule
